div_scheduler: RTL and testbench

Shares one iterative restoring divider among N requesters. Each requester issues dividend/divisor operands over a valid/ready handshake. A round-robin arbiter grants one request at a time. Results return on a single response port tagged with the requester index. The block sits between the integer-ALU issue ports and the sequential divider datapath, so no requester ever drives the divider directly.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_scheduler_if.sv | 32 +++
 rtl/div_scheduler_seq_div_core.sv | 80 ++++++++
 rtl/div_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_div_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider scheduler and its datapath.
package div_pkg;

  // IDLE: arbitrate, CALC: iterate the divider, DONE: hold the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Divide-by-zero quotient; consumers slice the low M bits
  localparam logic [63:0] DIV_DBZ_QUOTIENT = '1;

  // Requester index width for n requesters
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Request/response bundle between the ALU issue ports (master) and the
// divider scheduler (slave).
interface div_scheduler_if #(
  parameter int M = 32,
  parameter int N = 4
);
  import div_pkg::*;

  localparam int ID_W = id_w(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*M-1:0] req_dividend;
  logic [N*M-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [M-1:0]   rsp_quotient;
  logic [M-1:0]   rsp_remainder;
  logic           rsp_dbz;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );

endinterface

// File: rtl/div_scheduler_seq_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; M iterations follow and done is high
// during the last one, with quotient/remainder showing that iteration's result.
module seq_div_core #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder
);

  localparam int CNT_W = $clog2(M);

  logic [2*M-1:0] pr_q, pr_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;

  logic [M:0]     hi_shift;
  logic [M-1:0]   hi_sub;
  logic [2*M-1:0] step;

  // One restoring step: shift left, trial-subtract, keep on success
  always_comb begin
    hi_shift = pr_q[2*M-1:M-1];
    hi_sub   = hi_shift[M-1:0] - dvs_q;
    if (hi_shift >= {1'b0, dvs_q}) begin
      step = {hi_sub, pr_q[M-2:0], 1'b1};
    end else begin
      step = {hi_shift[M-1:0], pr_q[M-2:0], 1'b0};
    end
  end

  // Load on start, otherwise iterate while the down-counter runs out
  always_comb begin
    pr_d   = pr_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      pr_d   = {{M{1'b0}}, dividend};
      dvs_d  = divisor;
      cnt_d  = CNT_W'(M - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      pr_d  = step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      pr_q   <= pr_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = step[M-1:0];
  assign remainder = step[2*M-1:M];

endmodule

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one sequential divider among N requesters.
// Optional feature: DIV_SCHED_PERF_EN adds the perf_ops completion counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate; the granted requester sees req_ready
// CALC  | divider iterating on the latched operands
// DONE  | response held until rsp_valid && rsp_ready
module div_scheduler
  import div_pkg::*;
#(
  parameter int M = 32,
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  div_scheduler_if.slave bus
`ifdef DIV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_ops
`endif
);

  localparam int ID_W = id_w(N);

  div_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [M-1:0]    dividend_q, dividend_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [M-1:0]    rsp_quo_q, rsp_quo_d;
  logic [M-1:0]    rsp_rem_q, rsp_rem_d;
  logic            rsp_dbz_q, rsp_dbz_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant;
  logic [ID_W:0]   scan_sum;
  logic [M-1:0]    g_dividend, g_divisor;
  logic            accept, rsp_hs;
  logic            core_start, core_busy, core_done;
  logic [M-1:0]    core_quo, core_rem;

  // Round-robin grant: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan_sum  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (scan_sum >= (ID_W + 1)'(N)) begin
        scan_sum = scan_sum - (ID_W + 1)'(N);
      end
      if (bus.req_valid[scan_sum[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan_sum[ID_W-1:0];
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    g_dividend = '0;
    g_divisor  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == ID_W'(i)) begin
        g_dividend = bus.req_dividend[i*M +: M];
        g_divisor  = bus.req_divisor[i*M +: M];
      end
    end
  end

  // req_ready is held low while reset is asserted
  assign accept = reset && (state_q == IDLE) && grant_vld;
  assign rsp_hs = (state_q == DONE) && rsp_valid_q && bus.rsp_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero divisor skips the divider entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (g_divisor == '0) ? DONE : CALC;
      // A core that went idle without done means the start was lost; recover
      CALC: if (core_done) state_d = DONE;
            else if (!core_busy) state_d = IDLE;
      DONE: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one-hot ready to the granted requester, divider start
  always_comb begin
    bus.req_ready = '0;
    core_start    = 1'b0;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
      core_start           = (g_divisor != '0);
    end
  end

  // Latches and response registers. The divide-by-zero result is formed in
  // the first DONE cycle from the latched dividend.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    dividend_d  = dividend_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_quo_d   = rsp_quo_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_dbz_d   = rsp_dbz_q;
    if (accept) begin
      rr_ptr_d   = (grant == ID_W'(N - 1)) ? '0 : grant + ID_W'(1);
      id_d       = grant;
      dividend_d = g_dividend;
    end
    if ((state_q == CALC) && core_done) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_quo_d   = core_quo;
      rsp_rem_d   = core_rem;
      rsp_dbz_d   = 1'b0;
    end else if ((state_q == DONE) && !rsp_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_quo_d   = DIV_DBZ_QUOTIENT[M-1:0];
      rsp_rem_d   = dividend_q;
      rsp_dbz_d   = 1'b1;
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Register update for latches and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      dividend_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      dividend_q  <= dividend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_quo_q   <= rsp_quo_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_dbz_q   <= rsp_dbz_d;
    end
  end

  seq_div_core #(.M(M)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .dividend  (g_dividend),
    .divisor   (g_divisor),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_quotient  = rsp_quo_q;
  assign bus.rsp_remainder = rsp_rem_q;
  assign bus.rsp_dbz       = rsp_dbz_q;

`ifdef DIV_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Completed-operation counter, wraps naturally
  always_comb begin
    perf_d = perf_q;
    if (rsp_hs) perf_d = perf_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler (M=32, N=4).
module tb_div_scheduler;
  localparam int M = 32;
  localparam int N = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_scheduler_if #(.M(M), .N(N)) bus ();

`ifdef DIV_SCHED_PERF_EN
  logic [31:0] perf_ops;
`endif

  div_scheduler #(.M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DIV_SCHED_PERF_EN
    ,
    .perf_ops (perf_ops)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    logic [31:0] q;
    logic [31:0] r;
    logic        d;
  } vec_t;

  vec_t vecs[10];
  int n_checks = 0;
  int n_pass = 0;
  int rr_model = 0;
  int ops_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_dividend[id*M +: M] = a;
    bus.req_divisor[id*M +: M]  = b;
  endtask

  // Grant predicted from the round-robin rule over the model pointer
  function automatic int model_grant(input logic [N-1:0] mask);
    int g;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && mask[(rr_model + k) % N]) g = (rr_model + k) % N;
    return g;
  endfunction

  task automatic run_op(input logic [N-1:0] mask, input int stall,
                        output int g_o, output logic [31:0] q_o,
                        output logic [31:0] r_o, output logic d_o);
    int g;
    int lat;
    logic [31:0] a, b, eq, er;
    logic [N-1:0] onehot;
    logic ready_seen;
    g = model_grant(mask);
    onehot = '0;
    onehot[g] = 1'b1;
    bus.req_valid = mask;
    #1;
    check("grant", 64'(bus.req_ready), 64'(onehot));
    a = bus.req_dividend[g*M +: M];
    b = bus.req_divisor[g*M +: M];
    if (b == 0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    tick();
    rr_model = (g + 1) % N;
    lat = 0;
    ready_seen = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 200) begin
      if (bus.req_ready != '0) ready_seen = 1'b1;
      tick();
      lat++;
    end
    check("latency", 64'(lat), (b == 0) ? 64'd1 : 64'(M));
    check("ready_low_busy", 64'(ready_seen), 64'd0);
    check("rsp_id", 64'(bus.rsp_id), 64'(g));
    check("model_quotient", 64'(bus.rsp_quotient), 64'(eq));
    check("model_remainder", 64'(bus.rsp_remainder), 64'(er));
    check("model_dbz", 64'(bus.rsp_dbz), (b == 0) ? 64'd1 : 64'd0);
    g_o = g;
    q_o = bus.rsp_quotient;
    r_o = bus.rsp_remainder;
    d_o = bus.rsp_dbz;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_quotient", 64'(bus.rsp_quotient), 64'(q_o));
      check("hold_remainder", 64'(bus.rsp_remainder), 64'(r_o));
      check("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    // Requests stay valid across the response handshake: no accept in DONE
    bus.rsp_ready = 1'b1;
    tick();
    ops_done++;
    onehot = '0;
    onehot[model_grant(mask)] = 1'b1;
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("idle_after_rsp", 64'(bus.req_ready), 64'(onehot));
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    logic [31:0] q, r;
    logic d;
    logic [N-1:0] m;
    int seen;

    vecs[0] = '{2, 32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{1, 32'd55, 32'd0, 0, 32'hFFFF_FFFF, 32'd55, 1'b1};
    vecs[2] = '{3, 32'hFFFF_FFFF, 32'd1, 10, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[3] = '{0, 32'd0, 32'd5, 1, 32'd0, 32'd0, 1'b0};
    vecs[4] = '{2, 32'd7, 32'd100, 2, 32'd0, 32'd7, 1'b0};
    vecs[5] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd1, 32'd0, 1'b0};
    vecs[6] = '{0, 32'h8000_0000, 32'd3, 0, 32'h2AAA_AAAA, 32'd2, 1'b0};
    vecs[7] = '{1, 32'd0, 32'd0, 3, 32'hFFFF_FFFF, 32'd0, 1'b1};
    vecs[8] = '{2, 32'd12345678, 32'd1000, 0, 32'd12345, 32'd678, 1'b0};
    vecs[9] = '{0, 32'd1, 32'd2, 0, 32'd0, 32'd1, 1'b0};

    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    bus.req_valid = '1;
    #1;
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("reset_quotient", 64'(bus.rsp_quotient), 64'd0);
    check("reset_remainder", 64'(bus.rsp_remainder), 64'd0);
    check("reset_dbz", 64'(bus.rsp_dbz), 64'd0);
`ifdef DIV_SCHED_PERF_EN
    check("reset_perf", 64'(perf_ops), 64'd0);
`endif
    bus.req_valid = '0;
    reset = 1'b1;
    tick();

    // All requesters valid: grants rotate 0,1,2,3 then wrap to 0
    for (int i = 0; i < N; i++) set_ops(i, 32'(100 + i * 17), 32'(i + 3));
    for (int i = 0; i < N; i++) begin
      run_op('1, 0, g, q, r, d);
      check("rr_order", 64'(g), 64'(i));
    end
    bus.req_valid = '1;
    #1;
    check("rr_wrap", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    tick();

    for (int i = 0; i < 10; i++) begin
      set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
      m = '0;
      m[vecs[i].id] = 1'b1;
      run_op(m, vecs[i].stall, g, q, r, d);
      check("vec_quotient", 64'(q), 64'(vecs[i].q));
      check("vec_remainder", 64'(r), 64'(vecs[i].r));
      check("vec_dbz", 64'(d), 64'(vecs[i].d));
      tick();
    end

    // Reset in the middle of CALC drops the operation and the pointer
    set_ops(2, 32'd100, 32'd7);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (10) tick();
    reset = 1'b0;
    bus.req_valid = '1;
    #1;
    check("midreset_ready", 64'(bus.req_ready), 64'd0);
    check("midreset_valid", 64'(bus.rsp_valid), 64'd0);
`ifdef DIV_SCHED_PERF_EN
    check("midreset_perf", 64'(perf_ops), 64'd0);
`endif
    bus.req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    rr_model = 0;
    ops_done = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    check("no_rsp_after_reset", 64'(seen), 64'd0);
    bus.req_valid = '1;
    #1;
    check("first_grant_after_reset", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    set_ops(0, 32'd9, 32'd3);
    run_op(4'b0001, 0, g, q, r, d);
    check("post_reset_quotient", 64'(q), 64'd3);
    check("post_reset_remainder", 64'(r), 64'd0);
    tick();

    // Randomized traffic against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
        case ($urandom_range(0, 3))
          0: b = 32'd0;
          1: b = 32'($urandom_range(1, 255));
          2: b = 32'($urandom);
          default: b = 32'($urandom_range(1, 65535));
        endcase
        set_ops(i, a, b);
      end
      m = N'($urandom_range(1, 15));
      run_op(m, $urandom_range(0, 3), g, q, r, d);
`ifdef DIV_SCHED_PERF_EN
      if (ops_done == 5) check("perf_five", 64'(perf_ops), 64'd5);
`endif
      if ($urandom_range(0, 1) == 1) tick();
    end

`ifdef DIV_SCHED_PERF_EN
    check("perf_final", 64'(perf_ops), 64'(ops_done));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
